// File: rtl/axi_wr_cmd_seq_pkg.sv
// Shared definitions for the PCIS write-command sequencer: register map,
// control/status bit positions, sequencer states and the queued command type.
package axi_wr_cmd_seq_pkg;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_ADDR_HI = 8'h08;
  localparam logic [7:0] REG_ADDR_LO = 8'h0C;
  localparam logic [7:0] REG_PUSH    = 8'h10;
  localparam logic [7:0] REG_DONE    = 8'h14;

  localparam int CTRL_START   = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_ERR = 2;

  localparam int ST_BUSY      = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVF       = 18;
  localparam int ST_ALIGN     = 19;
  localparam int ST_BRESP_ERR = 20;

  localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } seq_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  fill;
  } wr_cmd_t;

  // Writes go out as full 512b beats, so the low 6 address bits must be zero.
  function automatic logic is_beat_aligned(input logic [31:0] addr_lo);
    return addr_lo[5:0] == 6'd0;
  endfunction

endpackage

// File: rtl/axi_wr_cmd_seq_if.sv
// Bundle of the config register bus, the command link to the write master,
// the completion input and the busy flag.
interface axi_wr_cmd_seq_if;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ack;
  logic [31:0] cfg_rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_fill;
  logic        cmp_valid;
  logic [1:0]  cmp_resp;
  logic        busy;

  // Sequencer side.
  modport slave (
    input  cfg_wr, cfg_rd, cfg_addr, cfg_wdata, cmd_ready, cmp_valid, cmp_resp,
    output cfg_ack, cfg_rdata, cmd_valid, cmd_addr, cmd_fill, busy
  );

  // Software / write-master side.
  modport master (
    output cfg_wr, cfg_rd, cfg_addr, cfg_wdata, cmd_ready, cmp_valid, cmp_resp,
    input  cfg_ack, cfg_rdata, cmd_valid, cmd_addr, cmd_fill, busy
  );
endinterface

// File: rtl/axi_wr_cmd_seq_fifo.sv
// Single-clock show-ahead command FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB difference; level is their
// difference and wraps cleanly at DEPTH.
module cmd_sync_fifo
  import axi_wr_cmd_seq_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = wr_cmd_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  input  logic        flush,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  T            mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A push into a full queue still lands when a pop frees a slot that same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; flush discards every entry at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_wr_cmd_seq.sv
// Command sequencer for the PCIS AXI write master. Software stages
// {address, fill} entries through config registers, then START walks the queue,
// handing one command at a time to the master and waiting for its completion.
module axi_wr_cmd_seq
  import axi_wr_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             aclk,
  input  logic             areset,
  axi_wr_cmd_seq_if.slave  bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic             done_clr;
  logic             flush_pend;

  logic [31:0]      addr_hi;
  logic [31:0]      addr_lo;
  logic [CNT_W-1:0] done_cnt;
  logic             ovf_flag;
  logic             align_flag;
  logic             bresp_flag;

  logic             ack_vld_p1;
  logic [31:0]      rdata_p1;
  logic [31:0]      rd_mux;

  logic             ctrl_wr;
  logic             start;
  logic             flush;
  logic             clr_err;
  logic             push_req;
  logic             push_ok;
  logic             align_set;
  logic             ovf_set;
  logic             bresp_set;
  logic             fire;
  logic             cmp_in_wait;

  wr_cmd_t          push_cmd;
  wr_cmd_t          head;
  logic             q_full;
  logic             q_empty;
  logic [LVL_W-1:0] q_level;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ctrl_wr     = bus.cfg_wr && (bus.cfg_addr == REG_CTRL);
  assign start       = ctrl_wr && bus.cfg_wdata[CTRL_START];
  assign flush       = ctrl_wr && bus.cfg_wdata[CTRL_FLUSH];
  assign clr_err     = ctrl_wr && bus.cfg_wdata[CTRL_CLR_ERR];
  assign push_req    = bus.cfg_wr && (bus.cfg_addr == REG_PUSH);
  assign push_ok     = push_req && is_beat_aligned(addr_lo);
  assign align_set   = push_req && !is_beat_aligned(addr_lo);
  assign fire        = bus.cmd_valid && bus.cmd_ready;
  assign ovf_set     = push_ok && q_full && !fire;
  assign cmp_in_wait = (state == WAIT) && bus.cmp_valid;
  assign bresp_set   = cmp_in_wait && (bus.cmp_resp != 2'b00);
  assign push_cmd    = '{addr: {addr_hi, addr_lo}, fill: bus.cfg_wdata[7:0]};

  cmd_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (wr_cmd_t)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push_ok),
    .din   (push_cmd),
    .pop   (fire),
    .flush (flush),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level)
  );

  assign bus.cmd_valid = (state == ISSUE);
  assign bus.cmd_addr  = head.addr;
  assign bus.cmd_fill  = head.fill;
  assign bus.busy      = (state != IDLE);
  assign bus.cfg_ack   = ack_vld_p1;
  assign bus.cfg_rdata = rdata_p1;

  // Sequencer state register.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an accepted START also clears the completion counter.
  always_comb begin
    state_nxt = state;
    done_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          done_clr = 1'b1;
          if (!q_empty) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (fire)       state_nxt = WAIT;
        else if (flush) state_nxt = IDLE;
      end
      WAIT: begin
        if (bus.cmp_valid) begin
          if (flush_pend || flush || q_empty) state_nxt = IDLE;
          else                                state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush with a command in flight must still end the run once that command completes.
  always_ff @(posedge aclk) begin
    if (areset)                                              flush_pend <= 1'b0;
    else if (cmp_in_wait)                                    flush_pend <= 1'b0;
    else if (flush && ((state == WAIT) || (state == ISSUE && fire))) flush_pend <= 1'b1;
  end

  // Completion counter since the last accepted START, saturating.
  always_ff @(posedge aclk) begin
    if (areset)           done_cnt <= '0;
    else if (done_clr)    done_cnt <= '0;
    else if (cmp_in_wait) done_cnt <= sat_inc(done_cnt);
  end

  // Sticky error flags; a new error in the same cycle as CLR_ERR survives.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_flag   <= 1'b0;
      align_flag <= 1'b0;
      bresp_flag <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf_flag   <= 1'b0;
        align_flag <= 1'b0;
        bresp_flag <= 1'b0;
      end
      if (ovf_set)   ovf_flag   <= 1'b1;
      if (align_set) align_flag <= 1'b1;
      if (bresp_set) bresp_flag <= 1'b1;
    end
  end

  // Staging address registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_hi <= '0;
      addr_lo <= '0;
    end else if (bus.cfg_wr) begin
      if (bus.cfg_addr == REG_ADDR_HI) addr_hi <= bus.cfg_wdata;
      if (bus.cfg_addr == REG_ADDR_LO) addr_lo <= bus.cfg_wdata;
    end
  end

  // Register read decode.
  always_comb begin
    rd_mux = RD_UNMAPPED;
    case (bus.cfg_addr)
      REG_CTRL:    rd_mux = '0;
      REG_STATUS: begin
        rd_mux               = '0;
        rd_mux[CNT_W-1:0]    = CNT_W'(q_level);
        rd_mux[ST_BUSY]      = bus.busy;
        rd_mux[ST_FULL]      = q_full;
        rd_mux[ST_OVF]       = ovf_flag;
        rd_mux[ST_ALIGN]     = align_flag;
        rd_mux[ST_BRESP_ERR] = bresp_flag;
      end
      REG_ADDR_HI: rd_mux = addr_hi;
      REG_ADDR_LO: rd_mux = addr_lo;
      REG_PUSH:    rd_mux = '0;
      REG_DONE:    rd_mux = 32'(done_cnt);
      default:     rd_mux = RD_UNMAPPED;
    endcase
  end

  // ---- stage p1: access acknowledge and registered read data ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      ack_vld_p1 <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      ack_vld_p1 <= bus.cfg_wr || bus.cfg_rd;
      rdata_p1   <= bus.cfg_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_axi_wr_cmd_seq.sv
// Directed bench for axi_wr_cmd_seq: a queue-level model of what software
// pushed, a compare process on the command link, and register-read checks.
module tb_axi_wr_cmd_seq;
  import axi_wr_cmd_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_wr_cmd_seq_if bus();

  axi_wr_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  wr_cmd_t sw_q[$];
  wr_cmd_t issued[$];
  bit      m_ovf = 0, m_align = 0, m_bresp = 0;
  int      m_done = 0;
  int      cmp_delay = 3;
  int      cmp_n = 0;
  int      err_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s = 32'h0;
    s[7:0]         = 8'(sw_q.size());
    s[ST_BUSY]     = busy;
    s[ST_FULL]     = (sw_q.size() == DEPTH);
    s[ST_OVF]      = m_ovf;
    s[ST_ALIGN]    = m_align;
    s[ST_BRESP_ERR] = m_bresp;
    return s;
  endfunction

  task automatic cfg_xfer(input bit is_wr, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    @(posedge aclk); #1;
    bus.cfg_wr = is_wr; bus.cfg_rd = !is_wr; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(posedge aclk); #1;
    bus.cfg_wr = 1'b0; bus.cfg_rd = 1'b0;
    rd = bus.cfg_rdata;
    check("cfg_ack", bus.cfg_ack, 1'b1);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cfg_xfer(1'b1, a, d, dummy);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    cfg_xfer(1'b0, a, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic push_entry(input logic [63:0] addr, input logic [7:0] fill);
    cfg_write(REG_ADDR_HI, addr[63:32]);
    cfg_write(REG_ADDR_LO, addr[31:0]);
    cfg_write(REG_PUSH, {24'h0, fill});
    if (addr[5:0] != 6'd0)          m_align = 1;
    else if (sw_q.size() >= DEPTH)  m_ovf = 1;
    else                            sw_q.push_back('{addr: addr, fill: fill});
  endtask

  task automatic ctrl(input logic [2:0] bits);
    cfg_write(REG_CTRL, {29'h0, bits});
    if (bits[CTRL_FLUSH])   sw_q.delete();
    if (bits[CTRL_CLR_ERR]) begin m_ovf = 0; m_align = 0; m_bresp = 0; end
    if (bits[CTRL_START])   m_done = 0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (bus.busy && n < max) begin @(posedge aclk); #1; n++; end
    check(name, bus.busy, 1'b0);
  endtask

  // Command-link compare: order/content against the model, hold while stalled,
  // and no valid while the model has nothing to issue.
  logic        prev_valid = 0, prev_fire = 0;
  logic [63:0] prev_addr;
  logic [7:0]  prev_fill;
  always @(negedge aclk) begin
    if (areset) begin
      prev_valid = 0; prev_fire = 0;
    end else begin
      if (prev_valid && !prev_fire && bus.cmd_valid) begin
        check("hold_addr", bus.cmd_addr, prev_addr);
        check("hold_fill", bus.cmd_fill, prev_fill);
      end
      if (sw_q.size() == 0) check("no_cmd_when_empty", bus.cmd_valid, 1'b0);
      if (bus.cmd_valid && bus.cmd_ready && sw_q.size() != 0) begin
        check("cmd_addr", bus.cmd_addr, sw_q[0].addr);
        check("cmd_fill", bus.cmd_fill, sw_q[0].fill);
        void'(sw_q.pop_front());
        issued.push_back('{addr: bus.cmd_addr, fill: bus.cmd_fill});
      end
      prev_valid = bus.cmd_valid;
      prev_fire  = bus.cmd_valid && bus.cmd_ready;
      prev_addr  = bus.cmd_addr;
      prev_fill  = bus.cmd_fill;
    end
  end

  // Write-master completion responder.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset && bus.cmd_valid && bus.cmd_ready) begin
        repeat (cmp_delay) @(posedge aclk);
        #1;
        bus.cmp_resp  = (cmp_n == err_at) ? 2'b10 : 2'b00;
        bus.cmp_valid = 1'b1;
        m_done++;
        if (bus.cmp_resp != 2'b00) m_bresp = 1;
        @(posedge aclk); #1;
        bus.cmp_valid = 1'b0;
        bus.cmp_resp  = 2'b00;
        cmp_n++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bus.cfg_wr = 0; bus.cfg_rd = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.cmd_ready = 0; bus.cmp_valid = 0; bus.cmp_resp = 0;

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst_cfg_ack", bus.cfg_ack, 1'b0);
    check("rst_cfg_rdata", bus.cfg_rdata, 32'h0);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    areset = 1'b0;
    read_check("rst_status", REG_STATUS, 32'h0);
    @(posedge aclk); #1;
    check("ack_one_cycle", bus.cfg_ack, 1'b0);
    read_check("rst_done", REG_DONE, 32'h0);
    read_check("unmapped", 8'h20, 32'hFFFF_FFFF);
    read_check("ctrl_reads_0", REG_CTRL, 32'h0);

    // 1: four entries, ready high, completion 3 cycles after each handshake
    bus.cmd_ready = 1'b1;
    base = issued.size();
    push_entry(64'h0000_0000_0000_1F00, 8'hAA);
    push_entry(64'h0000_0004_0000_0000, 8'hBB);
    push_entry(64'h0000_0008_0000_0000, 8'hCC);
    push_entry(64'h0000_000C_0000_0000, 8'hDD);
    read_check("t1_addr_hi_rb", REG_ADDR_HI, 32'h0000_000C);
    read_check("t1_status_pre", REG_STATUS, exp_status(0));
    ctrl(3'b001);
    wait_idle("t1_idle", 200);
    check("t1_issued", issued.size() - base, 4);
    if (issued.size() - base == 4) begin
      check("t1_cmd0_addr", issued[base].addr, 64'h1F00);
      check("t1_cmd0_fill", issued[base].fill, 8'hAA);
      check("t1_cmd1_addr", issued[base+1].addr, 64'h4_0000_0000);
      check("t1_cmd3_fill", issued[base+3].fill, 8'hDD);
    end
    read_check("t1_done_lit", REG_DONE, 32'd4);
    read_check("t1_done_model", REG_DONE, 32'(m_done));
    read_check("t1_status", REG_STATUS, 32'h0);

    // 2: overflow
    for (int i = 0; i < DEPTH + 1; i++) push_entry(64'h1000 + 64'(i) * 64, 8'(i));
    read_check("t2_status_lit", REG_STATUS, 32'h0006_0010);
    read_check("t2_status_model", REG_STATUS, exp_status(0));
    ctrl(3'b100);
    read_check("t2_clr_err", REG_STATUS, 32'h0002_0010);
    ctrl(3'b010);
    read_check("t2_flushed", REG_STATUS, exp_status(0));

    // 3: misaligned push
    push_entry(64'h0000_0000_0000_1F04, 8'h11);
    read_check("t3_align_lit", REG_STATUS, 32'h0008_0000);
    read_check("t3_align_model", REG_STATUS, exp_status(0));
    ctrl(3'b100);

    // 4: master stalls with ready low
    bus.cmd_ready = 1'b0;
    base = issued.size();
    push_entry(64'h0000_0001_0000_0040, 8'h5A);
    push_entry(64'h0000_0001_0000_0080, 8'hA5);
    ctrl(3'b001);
    repeat (10) @(posedge aclk);
    #1;
    check("t4_valid_held", bus.cmd_valid, 1'b1);
    check("t4_addr_held", bus.cmd_addr, 64'h1_0000_0040);
    check("t4_fill_held", bus.cmd_fill, 8'h5A);
    read_check("t4_no_pop", REG_STATUS, 32'h0001_0002);
    bus.cmd_ready = 1'b1;
    wait_idle("t4_idle", 200);
    check("t4_issued", issued.size() - base, 2);
    read_check("t4_done", REG_DONE, 32'd2);

    // 5: second completion carries SLVERR
    base = issued.size();
    err_at = cmp_n + 1;
    push_entry(64'h2000, 8'h01);
    push_entry(64'h2040, 8'h02);
    push_entry(64'h2080, 8'h03);
    ctrl(3'b001);
    wait_idle("t5_idle", 200);
    check("t5_issued", issued.size() - base, 3);
    read_check("t5_done", REG_DONE, 32'd3);
    read_check("t5_bresp_lit", REG_STATUS, 32'h0010_0000);
    read_check("t5_bresp_model", REG_STATUS, exp_status(0));
    ctrl(3'b100);
    err_at = -1;

    // 6: FLUSH while a command is outstanding
    cmp_delay = 8;
    base = issued.size();
    push_entry(64'h3000, 8'h31);
    push_entry(64'h3040, 8'h32);
    push_entry(64'h3080, 8'h33);
    ctrl(3'b001);
    n = 0;
    while (issued.size() == base && n < 20) begin @(posedge aclk); #1; n++; end
    check("t6_first_issued", issued.size() - base, 1);
    ctrl(3'b010);
    wait_idle("t6_idle", 100);
    repeat (10) @(posedge aclk);
    #1;
    check("t6_only_one", issued.size() - base, 1);
    read_check("t6_done", REG_DONE, 32'd1);
    read_check("t6_status", REG_STATUS, 32'h0);
    ctrl(3'b001);
    check("t6_empty_start_idle", bus.busy, 1'b0);
    read_check("t6_done_cleared", REG_DONE, 32'h0);
    cmp_delay = 3;

    // Reset mid-operation
    bus.cmd_ready = 1'b0;
    push_entry(64'h4000, 8'h44);
    ctrl(3'b001);
    @(posedge aclk); #1;
    areset = 1'b1;
    sw_q.delete(); m_done = 0; m_ovf = 0; m_align = 0; m_bresp = 0;
    repeat (2) @(posedge aclk);
    #1;
    check("mid_rst_valid", bus.cmd_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    areset = 1'b0;
    read_check("mid_rst_status", REG_STATUS, exp_status(0));
    read_check("mid_rst_addr_lo", REG_ADDR_LO, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
